fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_return_stack.sv | 69 ++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: default geometry and FSM state encoding.
// Build option FETCH_STACK_GUARD_EN (see fetch_unit.sv) does not affect this file.
package fetch_unit_pkg;

   localparam int ADDR_WIDTH_DEF  = 16;
   localparam int INSTR_WIDTH_DEF = 28;
   localparam int STACK_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Return-address stack for fetch_unit (module return_stack).
// FETCH_STACK_GUARD_EN: when defined, push on full / pop on empty are suppressed; otherwise the pointer wraps.
module return_stack
   import fetch_unit_pkg::*;
#(
   parameter int DATA_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = STACK_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty
);

`ifdef FETCH_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]         ptr_q, ptr_d;
   logic [PW:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]         top_idx;
   logic                  push_en;
   logic                  pop_en;

   // cnt_q only feeds full/empty; ptr_q is the circular write pointer
   assign full     = (cnt_q == (PW+1)'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign top_idx  = ptr_q - PW'(1);
   assign pop_data = mem_q[top_idx];
   assign push_en  = push & ~(GUARD & full);
   assign pop_en   = pop & ~push & ~(GUARD & empty);

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_en) begin
         mem_d[ptr_q] = push_data;
         ptr_d        = ptr_q + PW'(1);
         if (!full) cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop_en) begin
         ptr_d = top_idx;
         if (!empty) cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         mem_q <= '{default: '0};
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, output register, redirects (jump/call/ret) with one-bubble flush.
// FETCH_STACK_GUARD_EN: defined -> sticky oOverflow/oUnderflow and guarded stack; undefined -> flags tied 0.
//
// state    | meaning
// ST_INIT  | first cycle after reset release, nothing fetched
// ST_RUN   | normal fetch, stall hold, redirect sampling when oValid=1
// ST_FLUSH | bubble after redirect; fetches at new PC, requests ignored
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic                   Clock,
   input  logic                   Reset,
   output logic [ADDR_WIDTH-1:0]  oAddress,
   input  logic [INSTR_WIDTH-1:0] iInstruction,
   input  logic                   iStall,
   input  logic                   iJump,
   input  logic                   iCall,
   input  logic                   iRet,
   input  logic [ADDR_WIDTH-1:0]  iTarget,
   output logic [INSTR_WIDTH-1:0] oInstruction,
   output logic [ADDR_WIDTH-1:0]  oPC,
   output logic                   oValid,
   output logic                   oOverflow,
   output logic                   oUnderflow
);

`ifdef FETCH_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   fetch_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;

   logic                   stk_push;
   logic                   stk_pop;
   logic [ADDR_WIDTH-1:0]  stk_data;
   logic                   stk_full;
   logic                   stk_empty;

   return_stack #(
      .DATA_WIDTH (ADDR_WIDTH),
      .DEPTH      (STACK_DEPTH)
   ) u_return_stack (
      .clk       (Clock),
      .rst_n     (Reset),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (opc_q + ADDR_WIDTH'(1)),
      .pop_data  (stk_data),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      opc_d    = opc_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_RUN;
         ST_FLUSH: begin
            instr_d = iInstruction;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (valid_q && (iRet || iCall || iJump)) begin
               valid_d = 1'b0;
               state_d = ST_FLUSH;
               if (iRet) begin
                  stk_pop = 1'b1;
                  if (GUARD && stk_empty) begin
                     pc_d  = '0;
                     unf_d = 1'b1;
                  end else begin
                     pc_d = stk_data;
                  end
               end else if (iCall) begin
                  stk_push = 1'b1;
                  pc_d     = iTarget;
                  if (GUARD && stk_full) ovf_d = 1'b1;
               end else begin
                  pc_d = iTarget;
               end
            end else if (!iStall) begin
               instr_d = iInstruction;
               opc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + ADDR_WIDTH'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_INIT;
         pc_q    <= '0;
         instr_q <= '0;
         opc_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign oAddress     = pc_q;
   assign oInstruction = instr_q;
   assign oPC          = opc_q;
   assign oValid       = valid_q;
   assign oOverflow    = ovf_q;
   assign oUnderflow   = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, stack corner sequences, randomized run vs. reference model.
module tb_fetch_unit;

`ifdef FETCH_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] oAddress;
   logic [27:0] iInstruction;
   logic        iStall, iJump, iCall, iRet;
   logic [15:0] iTarget;
   logic [27:0] oInstruction;
   logic [15:0] oPC;
   logic        oValid, oOverflow, oUnderflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clock = ~Clock;

   function automatic logic [27:0] rom(input logic [15:0] a);
      return {a[11:0] ^ 12'h5A3, a};
   endfunction

   assign iInstruction = rom(oAddress);

   fetch_unit dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .oAddress     (oAddress),
      .iInstruction (iInstruction),
      .iStall       (iStall),
      .iJump        (iJump),
      .iCall        (iCall),
      .iRet         (iRet),
      .iTarget      (iTarget),
      .oInstruction (oInstruction),
      .oPC          (oPC),
      .oValid       (oValid),
      .oOverflow    (oOverflow),
      .oUnderflow   (oUnderflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: stack as a plain array, bounded list when guarded, ring when not.
   logic [15:0] m_pc, m_opc;
   logic [27:0] m_instr;
   bit          m_valid, m_init, m_flush, m_ovf, m_unf;
   logic [15:0] m_stk [8];
   int          m_cnt, m_sp;

   task automatic model_reset();
      m_pc = '0; m_opc = '0; m_instr = '0;
      m_valid = 0; m_init = 1; m_flush = 0; m_ovf = 0; m_unf = 0;
      m_cnt = 0; m_sp = 0;
      for (int i = 0; i < 8; i++) m_stk[i] = '0;
   endtask

   task automatic model_fetch();
      m_instr = rom(m_pc);
      m_opc   = m_pc;
      m_valid = 1;
      m_pc    = m_pc + 16'd1;
   endtask

   task automatic model_step();
      if (m_init) begin
         m_init = 0;
      end else if (m_flush) begin
         model_fetch();
         m_flush = 0;
      end else if (m_valid && (iRet || iCall || iJump)) begin
         if (iRet) begin
            if (GUARD) begin
               if (m_cnt == 0) begin m_pc = '0; m_unf = 1; end
               else begin m_cnt--; m_pc = m_stk[m_cnt]; end
            end else begin
               m_sp = (m_sp + 7) % 8;
               m_pc = m_stk[m_sp];
            end
         end else if (iCall) begin
            if (GUARD) begin
               if (m_cnt == 8) m_ovf = 1;
               else begin m_stk[m_cnt] = m_opc + 16'd1; m_cnt++; end
            end else begin
               m_stk[m_sp] = m_opc + 16'd1;
               m_sp = (m_sp + 1) % 8;
            end
            m_pc = iTarget;
         end else begin
            m_pc = iTarget;
         end
         m_valid = 0;
         m_flush = 1;
      end else if (!iStall) begin
         model_fetch();
      end
   endtask

   task automatic compare_model();
      chk("model_addr",  32'(oAddress),     32'(m_pc));
      chk("model_valid", 32'(oValid),       32'(m_valid));
      chk("model_opc",   32'(oPC),          32'(m_opc));
      chk("model_instr", 32'(oInstruction), 32'(m_instr));
      chk("model_ovf",   32'(oOverflow),    32'(m_ovf));
      chk("model_unf",   32'(oUnderflow),   32'(m_unf));
   endtask

   task automatic tick();
      @(posedge Clock);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic set_in(input bit st, input bit jp, input bit cl, input bit rt, input logic [15:0] tg);
      iStall = st; iJump = jp; iCall = cl; iRet = rt; iTarget = tg;
   endtask

   task automatic apply_reset();
      set_in(0, 0, 0, 0, 16'h0);
      Reset = 1'b0;
      model_reset();
      #2;
      @(negedge Clock);
      Reset = 1'b1;
   endtask

   typedef struct {
      bit          st, jp, cl, rt;
      logic [15:0] tgt;
      bit          ev;
      logic [15:0] eopc;
      logic [15:0] eaddr;
      bit          eunf;
   } vec_t;

   function automatic vec_t mk(input bit st, input bit jp, input bit cl, input bit rt, input logic [15:0] tgt,
                               input bit ev, input logic [15:0] eopc, input logic [15:0] eaddr, input bit eunf);
      vec_t v;
      v.st = st; v.jp = jp; v.cl = cl; v.rt = rt; v.tgt = tgt;
      v.ev = ev; v.eopc = eopc; v.eaddr = eaddr; v.eunf = eunf;
      return v;
   endfunction

   vec_t tbl [32];

   initial begin
      tbl[0]  = mk(0,0,0,0,16'h0,    0,16'h0,   16'h0,   0);
      tbl[1]  = mk(0,0,0,0,16'h0,    1,16'h0,   16'h1,   0);
      tbl[2]  = mk(0,0,0,0,16'h0,    1,16'h1,   16'h2,   0);
      tbl[3]  = mk(0,0,0,0,16'h0,    1,16'h2,   16'h3,   0);
      tbl[4]  = mk(0,0,0,0,16'h0,    1,16'h3,   16'h4,   0);
      tbl[5]  = mk(0,0,0,0,16'h0,    1,16'h4,   16'h5,   0);
      tbl[6]  = mk(0,0,0,0,16'h0,    1,16'h5,   16'h6,   0);
      tbl[7]  = mk(1,0,0,0,16'h0,    1,16'h5,   16'h6,   0);
      tbl[8]  = mk(1,0,0,0,16'h0,    1,16'h5,   16'h6,   0);
      tbl[9]  = mk(1,0,0,0,16'h0,    1,16'h5,   16'h6,   0);
      tbl[10] = mk(0,0,0,0,16'h0,    1,16'h6,   16'h7,   0);
      tbl[11] = mk(0,0,1,0,16'd32,   0,16'h0,   16'd32,  0);
      tbl[12] = mk(0,0,0,0,16'h0,    1,16'd32,  16'd33,  0);
      tbl[13] = mk(0,0,0,0,16'h0,    1,16'd33,  16'd34,  0);
      tbl[14] = mk(0,0,0,0,16'h0,    1,16'd34,  16'd35,  0);
      tbl[15] = mk(0,0,0,0,16'h0,    1,16'd35,  16'd36,  0);
      tbl[16] = mk(0,0,0,1,16'h0,    0,16'h0,   16'd7,   0);
      tbl[17] = mk(0,0,0,0,16'h0,    1,16'd7,   16'd8,   0);
      tbl[18] = mk(0,1,0,0,16'd13,   0,16'h0,   16'd13,  0);
      tbl[19] = mk(0,0,0,0,16'h0,    1,16'd13,  16'd14,  0);
      tbl[20] = mk(1,1,0,0,16'd100,  0,16'h0,   16'd100, 0);
      tbl[21] = mk(0,1,0,0,16'd50,   1,16'd100, 16'd101, 0);
      tbl[22] = mk(0,1,1,1,16'd200,  0,16'h0,   16'd0,   1);
      tbl[23] = mk(0,0,0,0,16'h0,    1,16'd0,   16'd1,   1);
      tbl[24] = mk(0,1,1,0,16'd40,   0,16'h0,   16'd40,  1);
      tbl[25] = mk(0,0,0,0,16'h0,    1,16'd40,  16'd41,  1);
      tbl[26] = mk(0,1,0,0,16'hFFFE, 0,16'h0,   16'hFFFE,1);
      tbl[27] = mk(0,0,0,0,16'h0,    1,16'hFFFE,16'hFFFF,1);
      tbl[28] = mk(0,0,0,0,16'h0,    1,16'hFFFF,16'h0,   1);
      tbl[29] = mk(0,0,0,0,16'h0,    1,16'h0,   16'h1,   1);
      tbl[30] = mk(0,0,0,1,16'h0,    0,16'h0,   16'h1,   1);
      tbl[31] = mk(0,0,0,0,16'h0,    1,16'h1,   16'h2,   1);

      // reset state
      set_in(0, 0, 0, 0, 16'h0);
      Reset = 1'b0;
      model_reset();
      #12;
      compare_model();
      @(negedge Clock);
      Reset = 1'b1;

      // directed table
      for (int i = 0; i < 32; i++) begin
         set_in(tbl[i].st, tbl[i].jp, tbl[i].cl, tbl[i].rt, tbl[i].tgt);
         tick();
         chk($sformatf("tbl%0d_valid", i), 32'(oValid),     32'(tbl[i].ev));
         chk($sformatf("tbl%0d_addr", i),  32'(oAddress),   32'(tbl[i].eaddr));
         chk($sformatf("tbl%0d_unf", i),   32'(oUnderflow), 32'(tbl[i].eunf & GUARD));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_opc", i),   32'(oPC),          32'(tbl[i].eopc));
            chk($sformatf("tbl%0d_instr", i), 32'(oInstruction), 32'(rom(tbl[i].eopc)));
         end
      end
      set_in(0, 0, 0, 0, 16'h0);

      // nine nested calls then nine returns
      apply_reset();
      tick();
      tick();
      for (int i = 0; i < 9; i++) begin
         set_in(0, 0, 1, 0, 16'h100 + 16'(i * 16));
         tick();
         set_in(0, 0, 0, 0, 16'h0);
         tick();
         if (i == 7) chk("ovf_after_8th_call", 32'(oOverflow), 32'(0));
      end
      chk("ovf_after_9th_call", 32'(oOverflow), 32'(GUARD));
      for (int i = 0; i < 9; i++) begin
         set_in(0, 0, 0, 1, 16'h0);
         tick();
         set_in(0, 0, 0, 0, 16'h0);
         if (i == 8) begin
            chk("unf_after_empty_ret", 32'(oUnderflow), 32'(GUARD));
            if (GUARD) chk("addr_after_empty_ret", 32'(oAddress), 32'(0));
         end
         tick();
      end
      if (GUARD) chk("opc_after_empty_ret", 32'(oPC), 32'(0));
      chk("ovf_sticky", 32'(oOverflow), 32'(GUARD));

      // reset asserted during the flush bubble
      set_in(0, 1, 0, 0, 16'd77);
      tick();
      set_in(0, 0, 0, 0, 16'h0);
      chk("in_flush_valid", 32'(oValid), 32'(0));
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      chk("rst_addr",  32'(oAddress),     32'(0));
      chk("rst_opc",   32'(oPC),          32'(0));
      chk("rst_instr", 32'(oInstruction), 32'(0));
      chk("rst_valid", 32'(oValid),       32'(0));
      chk("rst_ovf",   32'(oOverflow),    32'(0));
      chk("rst_unf",   32'(oUnderflow),   32'(0));
      @(negedge Clock);
      Reset = 1'b1;
      tick();
      chk("restart_init_valid", 32'(oValid), 32'(0));
      tick();
      chk("restart_valid", 32'(oValid), 32'(1));
      chk("restart_opc",   32'(oPC),    32'(0));

      // randomized run against the model
      for (int i = 0; i < 2000; i++) begin
         set_in(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 9) == 0,
                ($urandom % 10) == 0, 16'($urandom));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
